vga_frame_scanout: RTL and testbench

Display back end for the phrase-to-image CPU. Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock and continuously scans the 240x240, 1-bit-per-pixel image RAM. Each RAM bit becomes an RGB colour for an image window centred on screen; everything outside the window is drawn as a border colour. Sits directly downstream of the image RAM: it drives the RAM's read address and consumes `rdata[0]`.

---
 rtl/vga_frame_scanout.sv | 87 ++++++++
 tb/tb_vga_frame_scanout.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vga_frame_scanout.sv
// vga_frame_scanout: 640x480@60 VGA timing with a 1bpp image window read from the image RAM
module vga_frame_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC = 96,
    parameter int H_BACK = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT = 10,
    parameter int V_SYNC = 2,
    parameter int V_BACK = 33,
    parameter int IMG_W = 240,
    parameter int IMG_H = 240,
    parameter int X0 = 200,
    parameter int Y0 = 120,
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000,
    parameter logic [23:0] BORDER_COLOR = 24'h202020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        display_en,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_rdata,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_done
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    logic [9:0] h, v;
    logic [31:0] hx, vx;
    logic [15:0] row_base, col;
    logic [23:0] rgb;
    logic in_img, visible, h_last, rdata_unused;
    assign hx = {22'd0, h};
    assign vx = {22'd0, v};
    assign h_last = hx == H_TOTAL - 1;
    assign rdata_unused = ^ram_rdata[31:1];
    assign {vga_r, vga_g, vga_b} = rgb;
    // window decode and multiplier-free address: row base plus column offset, forced to 0 outside
    always_comb begin
        in_img = hx >= X0 && hx < X0 + IMG_W && vx >= Y0 && vx < Y0 + IMG_H;
        visible = hx < H_VISIBLE && vx < V_VISIBLE;
        ram_addr = in_img ? {16'd0, row_base + col} : '0;
    end
    // raster counters; both wrap together at the last pixel of the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_last ? '0 : h + 10'd1;
            if (h_last) v <= (vx == V_TOTAL - 1) ? '0 : v + 10'd1;
        end
    end
    // row base re-cleared at the first image line of every frame so it cannot drift
    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
            col <= '0;
        end else begin
            row_base <= (vx == Y0 && hx == 0) ? '0 :
                        (h_last && vx >= Y0 && vx < Y0 + IMG_H) ? row_base + 16'(IMG_W) : row_base;
            col <= in_img ? col + 16'd1 : '0;
        end
    end
    // output register: syncs, blank and colour all sampled from the same counter value
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rgb <= !visible ? '0 : (in_img && display_en) ? (ram_rdata[0] ? FG_COLOR : BG_COLOR) : BORDER_COLOR;
            vga_hs <= !(hx >= H_VISIBLE + H_FRONT && hx < H_VISIBLE + H_FRONT + H_SYNC);
            vga_vs <= !(vx >= V_VISIBLE + V_FRONT && vx < V_VISIBLE + V_FRONT + V_SYNC);
            vga_blank_n <= visible;
            frame_done <= h_last && vx == V_VISIBLE - 1;
        end
    end
endmodule

// File: tb/tb_vga_frame_scanout.sv
// tb_vga_frame_scanout: scaled-timing scanout checked cycle by cycle against an arithmetic raster model
module tb_vga_frame_scanout;
    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 48, VF = 2, VS = 2, VB = 3;
    localparam int IW = 24, IH = 20, X0 = 20, Y0 = 14;
    localparam int LINE = HV + HF + HS + HB;
    localparam int NLINES = VV + VF + VS + VB;
    localparam int FRAME = LINE * NLINES;
    localparam int NPIX = IW * IH;
    localparam logic [23:0] FG = 24'hFFFFFF, BG = 24'h000000, BORDER = 24'h202020;

    logic clk = 1'b0, rst = 1'b1, display_en = 1'b1;
    logic [31:0] ram_addr, ram_rdata = '0;
    logic [7:0] vga_r, vga_g, vga_b;
    logic vga_hs, vga_vs, vga_blank_n, frame_done;
    bit mem [NPIX];
    int checks = 0, errors = 0, k = 0, cyc = 0, hs_run = 0, vs_run = 0, last_fd = -1;

    vga_frame_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .IMG_W(IW), .IMG_H(IH), .X0(X0), .Y0(Y0),
        .FG_COLOR(FG), .BG_COLOR(BG), .BORDER_COLOR(BORDER)
    ) dut (
        .clk(clk), .rst(rst), .display_en(display_en),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .frame_done(frame_done)
    );

    always #20 clk = ~clk;

    always @(negedge clk) ram_rdata <= {31'd0, (ram_addr < NPIX) ? mem[ram_addr] : 1'b0};

    function automatic int px(int kk); return kk % LINE; endfunction
    function automatic int ln(int kk); return (kk / LINE) % NLINES; endfunction
    function automatic bit inimg(int kk);
        return px(kk) >= X0 && px(kk) < X0 + IW && ln(kk) >= Y0 && ln(kk) < Y0 + IH;
    endfunction
    function automatic int exp_addr(int kk);
        return inimg(kk) ? (ln(kk) - Y0) * IW + (px(kk) - X0) : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step(input bit r);
        int hh, vv;
        bit vis;
        logic [23:0] col;
        rst = r;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            k = 0;
            hs_run = 0;
            vs_run = 0;
            last_fd = -1;
            chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
            chk("rst_hs", vga_hs, 1);
            chk("rst_vs", vga_vs, 1);
            chk("rst_blank", vga_blank_n, 0);
            chk("rst_fd", frame_done, 0);
        end else begin
            hh = px(k);
            vv = ln(k);
            vis = hh < HV && vv < VV;
            col = !vis ? 24'h0 : (inimg(k) && display_en) ? (mem[exp_addr(k)] ? FG : BG) : BORDER;
            chk("blank", vga_blank_n, vis);
            chk("hs", vga_hs, !(hh >= HV + HF && hh < HV + HF + HS));
            chk("vs", vga_vs, !(vv >= VV + VF && vv < VV + VF + VS));
            chk("frame_done", frame_done, hh == LINE - 1 && vv == VV - 1);
            chk("rgb", {vga_r, vga_g, vga_b}, col);
            k++;
            if (!vga_hs) hs_run++;
            else begin
                if (hs_run > 0) chk("hs_width", hs_run, HS);
                hs_run = 0;
            end
            if (!vga_vs) vs_run++;
            else begin
                if (vs_run > 0) chk("vs_width", vs_run, VS * LINE);
                vs_run = 0;
            end
            if (frame_done) begin
                if (last_fd >= 0) chk("fd_period", cyc - last_fd, FRAME);
                last_fd = cyc;
            end
        end
        chk("addr", ram_addr, exp_addr(k));
    endtask

    task automatic run_to(input int hh, input int vv);
        for (int i = 0; i < FRAME + 2 && !(px(k) == hh && ln(k) == vv); i++) step(1'b0);
        chk("reach", (px(k) == hh && ln(k) == vv) ? 1 : 0, 1);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 1'($urandom);
        mem[0] = 1'b1;
        mem[1] = 1'b0;
        repeat (3) step(1'b1);
        run_to(X0 - 1, Y0);
        chk("addr_pre", ram_addr, 0);
        step(1'b0);
        chk("col_border", {vga_r, vga_g, vga_b}, BORDER);
        chk("addr_first", ram_addr, 0);
        step(1'b0);
        chk("col_fg", {vga_r, vga_g, vga_b}, FG);
        step(1'b0);
        chk("col_bg", {vga_r, vga_g, vga_b}, BG);
        run_to(X0 + IW - 1, Y0);
        chk("addr_row_end", ram_addr, IW - 1);
        run_to(X0, Y0 + 1);
        chk("addr_row2", ram_addr, IW);
        run_to(X0 + IW - 1, Y0 + IH - 1);
        chk("addr_last", ram_addr, NPIX - 1);
        step(1'b0);
        chk("addr_post", ram_addr, 0);
        for (int i = 0; i < NPIX; i++) mem[i] = 1'($urandom);
        for (int i = 0; i < FRAME; i++) begin
            display_en = 1'($urandom_range(0, 1));
            step(1'b0);
        end
        display_en = 1'b0;
        for (int i = 0; i < FRAME + LINE; i++) step(1'b0);
        display_en = 1'b1;
        repeat ($urandom_range(100, 2000)) step(1'b0);
        repeat (3) step(1'b1);
        step(1'b0);
        chk("blank_after_rst", vga_blank_n, 1);
        for (int i = 0; i < NPIX; i++) mem[i] = 1'(((i / IW) + (i % IW)) & 1);
        for (int i = 0; i < 2 * FRAME + LINE; i++) step(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
